// File: rtl/ycbcr_pkg.sv
// Shared field layout, pair-state encoding and chroma helpers for the 4:4:4 -> 4:2:2 packer.
package ycbcr_pkg;

  localparam int COMP_W = 8;

  // 24-bit input pixel {Cr, Cb, Y}
  localparam int PIX_Y_LSB  = 0;
  localparam int PIX_CB_LSB = 8;
  localparam int PIX_CR_LSB = 16;

  // 32-bit output pair {Cr_avg, Y1, Cb_avg, Y0}
  localparam int PAIR_Y0_LSB = 0;
  localparam int PAIR_CB_LSB = 8;
  localparam int PAIR_Y1_LSB = 16;
  localparam int PAIR_CR_LSB = 24;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } pair_state_e;

  function automatic logic [COMP_W-1:0] chroma_avg(input logic [COMP_W-1:0] a,
                                                   input logic [COMP_W-1:0] b,
                                                   input logic round);
    logic [COMP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{COMP_W{1'b0}}, round};
    return sum[COMP_W:1];
  endfunction

  // A single-pixel pair is packed by passing the same pixel twice; its average is itself.
  function automatic logic [31:0] pack_pair(input logic [23:0] p0,
                                            input logic [23:0] p1,
                                            input logic round);
    logic [31:0] r;
    r = '0;
    r[PAIR_Y0_LSB +: COMP_W] = p0[PIX_Y_LSB +: COMP_W];
    r[PAIR_Y1_LSB +: COMP_W] = p1[PIX_Y_LSB +: COMP_W];
    r[PAIR_CB_LSB +: COMP_W] = chroma_avg(p0[PIX_CB_LSB +: COMP_W], p1[PIX_CB_LSB +: COMP_W], round);
    r[PAIR_CR_LSB +: COMP_W] = chroma_avg(p0[PIX_CR_LSB +: COMP_W], p1[PIX_CR_LSB +: COMP_W], round);
    return r;
  endfunction

endpackage

// File: rtl/ycbcr_422_pair_packer.sv
// Packs horizontal YCbCr 4:4:4 pixel pairs into one 4:2:2 beat with averaged chroma.
module ycbcr_422_pair_packer
  import ycbcr_pkg::*;
#(
  parameter bit ROUND = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [23:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tlast,
  input  logic        s_axis_video_tuser,
  output logic [31:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tlast,
  output logic        m_axis_video_tuser,
  output logic        sync_err
);

  pair_state_e state_q, state_d;
  logic [23:0] hold_q, hold_d;
  logic        hold_user_q, hold_user_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        m_user_q, m_user_d;
  logic        sync_err_q, sync_err_d;
  logic        s_ready;
  logic        accept;

  // Storing pixel0 never touches the output register, so it may proceed under backpressure.
  assign s_ready = !m_valid_q || m_axis_video_tready ||
                   (state_q == EVEN && !s_axis_video_tlast);
  assign accept  = s_axis_video_tvalid && s_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_user_d = hold_user_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_user_d    = m_user_q;
    sync_err_d  = 1'b0;

    if (m_valid_q && m_axis_video_tready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == ODD && !s_axis_video_tuser) begin
        m_data_d  = pack_pair(hold_q, s_axis_video_tdata, ROUND);
        m_valid_d = 1'b1;
        m_last_d  = s_axis_video_tlast;
        m_user_d  = hold_user_q;
        state_d   = EVEN;
      end else begin
        // An SOF arriving while pixel0 is held restarts pairing on the new pixel.
        sync_err_d = (state_q == ODD);
        if (s_axis_video_tlast) begin
          m_data_d  = pack_pair(s_axis_video_tdata, s_axis_video_tdata, ROUND);
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          m_user_d  = s_axis_video_tuser;
          state_d   = EVEN;
        end else begin
          hold_d      = s_axis_video_tdata;
          hold_user_d = s_axis_video_tuser;
          state_d     = ODD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= EVEN;
      hold_q      <= '0;
      hold_user_q <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_user_q <= hold_user_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign s_axis_video_tready = s_ready;
  assign m_axis_video_tdata  = m_data_q;
  assign m_axis_video_tvalid = m_valid_q;
  assign m_axis_video_tlast  = m_last_q;
  assign m_axis_video_tuser  = m_user_q;
  assign sync_err            = sync_err_q;

endmodule

// File: tb/tb_ycbcr_422_pair_packer.sv
// Bench for ycbcr_422_pair_packer: ROUND=1 and ROUND=0 instances share stimulus; a queue model predicts beats.
module tb_ycbcr_422_pair_packer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast  = 1'b0;
  logic        s_tuser  = 1'b0;
  logic        m_tready = 1'b1;

  logic        s_tready1, s_tready0;
  logic [31:0] m_tdata1, m_tdata0;
  logic        m_tvalid1, m_tvalid0;
  logic        m_tlast1, m_tlast0;
  logic        m_tuser1, m_tuser0;
  logic        sync1, sync0;

  ycbcr_422_pair_packer #(.ROUND(1'b1)) dut1 (
    .clk(clk), .rstn(rstn),
    .s_axis_video_tdata(s_tdata), .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready1), .s_axis_video_tlast(s_tlast),
    .s_axis_video_tuser(s_tuser),
    .m_axis_video_tdata(m_tdata1), .m_axis_video_tvalid(m_tvalid1),
    .m_axis_video_tready(m_tready), .m_axis_video_tlast(m_tlast1),
    .m_axis_video_tuser(m_tuser1), .sync_err(sync1)
  );

  ycbcr_422_pair_packer #(.ROUND(1'b0)) dut0 (
    .clk(clk), .rstn(rstn),
    .s_axis_video_tdata(s_tdata), .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready0), .s_axis_video_tlast(s_tlast),
    .s_axis_video_tuser(s_tuser),
    .m_axis_video_tdata(m_tdata0), .m_axis_video_tvalid(m_tvalid0),
    .m_axis_video_tready(m_tready), .m_axis_video_tlast(m_tlast0),
    .m_axis_video_tuser(m_tuser0), .sync_err(sync0)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d0;
    logic        last;
    logic        user;
  } beat_t;

  function automatic logic [7:0] avg(input int a, input int b, input int r);
    return 8'((a + b + r) / 2);
  endfunction

  function automatic beat_t mk(input logic [23:0] p0, input logic [23:0] p1,
                               input logic last, input logic user);
    beat_t b;
    b.d1 = {avg(p0[23:16], p1[23:16], 1), p1[7:0], avg(p0[15:8], p1[15:8], 1), p0[7:0]};
    b.d0 = {avg(p0[23:16], p1[23:16], 0), p1[7:0], avg(p0[15:8], p1[15:8], 0), p0[7:0]};
    b.last = last;
    b.user = user;
    return b;
  endfunction

  // Model state: pixels of the pair being collected, beats loaded but not yet drained.
  logic [23:0] pend_pix[$];
  logic        pend_user[$];
  beat_t       expq[$];
  logic        fresh = 1'b0;
  beat_t       fresh_b;
  logic        exp_sync = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] stall_d1, stall_d0;
  logic        stall_last, stall_user;
  int          drains = 0;
  int          sync_cnt = 0;
  logic [31:0] last_d1 = '0, last_d0 = '0;
  logic        last_last = 1'b0, last_user = 1'b0;

  always @(negedge clk) begin
    beat_t b;
    logic  exp_rdy;
    if (!rstn) begin
      pend_pix.delete();
      pend_user.delete();
      expq.delete();
      fresh    = 1'b0;
      exp_sync = 1'b0;
      stall    = 1'b0;
    end else begin
      chk("sync_err_r1", sync1, exp_sync);
      chk("sync_err_r0", sync0, exp_sync);
      if (sync1) sync_cnt++;
      chk("m_tvalid_r1", m_tvalid1, expq.size() != 0);
      chk("m_tvalid_r0", m_tvalid0, expq.size() != 0);
      exp_rdy = (expq.size() == 0) || m_tready || (pend_pix.size() == 0 && !s_tlast);
      chk("s_tready_r1", s_tready1, exp_rdy);
      chk("s_tready_r0", s_tready0, exp_rdy);
      if (fresh) begin
        chk("latency_data_r1", m_tdata1, fresh_b.d1);
        chk("latency_data_r0", m_tdata0, fresh_b.d0);
        chk("latency_last", m_tlast1, fresh_b.last);
        chk("latency_user", m_tuser1, fresh_b.user);
      end
      if (stall) begin
        chk("stall_data_r1", m_tdata1, stall_d1);
        chk("stall_data_r0", m_tdata0, stall_d0);
        chk("stall_last", m_tlast1, stall_last);
        chk("stall_user", m_tuser1, stall_user);
      end
      stall      = m_tvalid1 && !m_tready;
      stall_d1   = m_tdata1;
      stall_d0   = m_tdata0;
      stall_last = m_tlast1;
      stall_user = m_tuser1;
      fresh      = 1'b0;
      exp_sync   = 1'b0;

      if (m_tvalid1 && m_tready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          b = expq.pop_front();
          chk("beat_data_r1", m_tdata1, b.d1);
          chk("beat_data_r0", m_tdata0, b.d0);
          chk("beat_last_r1", m_tlast1, b.last);
          chk("beat_last_r0", m_tlast0, b.last);
          chk("beat_user_r1", m_tuser1, b.user);
          chk("beat_user_r0", m_tuser0, b.user);
          drains++;
          last_d1   = m_tdata1;
          last_d0   = m_tdata0;
          last_last = m_tlast1;
          last_user = m_tuser1;
        end
      end

      if (s_tvalid && s_tready1) begin
        if (pend_pix.size() != 0 && s_tuser) begin
          pend_pix.delete();
          pend_user.delete();
          exp_sync = 1'b1;
        end
        pend_pix.push_back(s_tdata);
        pend_user.push_back(s_tuser);
        if (pend_pix.size() == 2 || s_tlast) begin
          b = mk(pend_pix[0], pend_pix[pend_pix.size() - 1], s_tlast, pend_user[0]);
          expq.push_back(b);
          fresh   = 1'b1;
          fresh_b = b;
          pend_pix.delete();
          pend_user.delete();
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input logic [23:0] d, input logic l, input logic u);
    logic acc;
    int   n;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_tready1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d;
    int  sc;
    logic acc;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid1, 0);
    chk("rst_tdata", m_tdata1, 0);
    chk("rst_tlast", m_tlast1, 0);
    chk("rst_tuser", m_tuser1, 0);
    chk("rst_sync_err", sync1, 0);
    chk("rst_tready", s_tready1, 1);
    rstn = 1'b1;

    // Pair averaging, rounding vs truncation
    m_tready = 1'b1;
    d = drains;
    send(24'h102030, 1'b0, 1'b1);
    send(24'h114050, 1'b1, 1'b0);
    idle(4);
    chk("pair_count", drains, d + 1);
    chk("pair_round1", last_d1, 32'h11503030);
    chk("pair_round0", last_d0, 32'h10503030);
    chk("pair_tuser", last_user, 1);
    chk("pair_tlast", last_last, 1);
    $display("[TB] pair averaging: r1=%h r0=%h", last_d1, last_d0);

    // Odd-length line of three pixels
    d = drains;
    send(24'h010203, 1'b0, 1'b0);
    send(24'h050607, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b1, 1'b0);
    idle(4);
    chk("odd_count", drains, d + 2);
    chk("odd_single_r1", last_d1, 32'hAACCBBCC);
    chk("odd_single_r0", last_d0, 32'hAACCBBCC);
    chk("odd_tlast", last_last, 1);
    $display("[TB] odd line: last beat=%h tlast=%0d", last_d1, last_last);

    // Mid-pair SOF
    sc = sync_cnt;
    d  = drains;
    send(24'h123456, 1'b0, 1'b0);
    send(24'h203040, 1'b0, 1'b1);
    send(24'h223250, 1'b1, 1'b0);
    idle(4);
    chk("sof_sync_pulses", sync_cnt, sc + 1);
    chk("sof_count", drains, d + 1);
    chk("sof_pair_r1", last_d1, 32'h21503140);
    chk("sof_pair_r0", last_d0, 32'h21503140);
    chk("sof_tuser", last_user, 1);
    $display("[TB] mid-pair sof: beat=%h tuser=%0d", last_d1, last_user);

    // Backpressure with full output register and pixel0 held
    d = drains;
    m_tready = 1'b0;
    send(24'h102030, 1'b0, 1'b0);
    send(24'h114050, 1'b0, 1'b0);
    send(24'h00FF01, 1'b0, 1'b0);
    s_tdata  = 24'h01FF02;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    s_tvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_tready_low", s_tready1, 0);
      @(posedge clk);
      #1;
    end
    m_tready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      acc = s_tready1;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("bp_release_timeout", 0, 1);
    s_tvalid = 1'b0;
    idle(4);
    chk("bp_count", drains, d + 2);
    chk("bp_pair_r1", last_d1, 32'h0102FF01);
    chk("bp_pair_r0", last_d0, 32'h0002FF01);
    $display("[TB] backpressure: last beat=%h", last_d1);

    // Asynchronous reset while ODD with a full output register
    m_tready = 1'b0;
    send(24'h111111, 1'b0, 1'b0);
    send(24'h222222, 1'b0, 1'b0);
    send(24'h333333, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_tvalid", m_tvalid1, 0);
    chk("arst_tdata", m_tdata1, 0);
    chk("arst_tlast", m_tlast1, 0);
    chk("arst_tuser", m_tuser1, 0);
    chk("arst_tready", s_tready1, 1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    m_tready = 1'b1;
    d = drains;
    send(24'h408010, 1'b0, 1'b0);
    send(24'h418120, 1'b0, 1'b0);
    idle(4);
    chk("arst_pair_count", drains, d + 1);
    chk("arst_pair_r1", last_d1, 32'h41208110);
    chk("arst_pair_r0", last_d0, 32'h40208010);
    $display("[TB] async reset recovery: beat=%h", last_d1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc = s_tvalid && s_tready1;
      @(posedge clk);
      #1;
      if (!s_tvalid || acc) begin
        s_tvalid = ($urandom_range(0, 9) < 7);
        s_tdata  = 24'($urandom);
        s_tlast  = ($urandom_range(0, 5) == 0);
        s_tuser  = ($urandom_range(0, 11) == 0);
      end
      m_tready = ($urandom_range(0, 9) < 7);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    idle(5);
    chk("final_queue_empty", expq.size(), 0);
    $display("[TB] random phase: %0d beats drained, %0d sync errors", drains, sync_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
